vrased_rst_ctrl: RTL and testbench



---
 rtl/vrased_rst_pkg.sv | 26 ++
 rtl/vrased_rst_log.sv | 32 +++
 rtl/vrased_rst_ctrl.sv | 105 ++++++++++
 tb/tb_vrased_rst_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/vrased_rst_pkg.sv
// Shared types and constants for the VRASED reset sequencer.
// Cause logging is compiled in only when VRASED_RST_LOG_EN is defined.
package vrased_rst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_HOLD       = 2'd1,
      ST_WAIT_FETCH = 2'd2
   } state_e;

   localparam int NVIOL            = 6;
   localparam int NCAUSE           = 7;
   localparam int CAUSE_XSTACK     = 0;
   localparam int CAUSE_AC         = 1;
   localparam int CAUSE_ATOMIC     = 2;
   localparam int CAUSE_DMA_AC     = 3;
   localparam int CAUSE_DMA_DETECT = 4;
   localparam int CAUSE_DMA_XSTACK = 5;
   localparam int CAUSE_TIMEOUT    = 6;

   // Counter width that never collapses to zero bits for tiny limits.
   function automatic int cnt_width(input int limit);
      return (limit > 2) ? $clog2(limit) : 1;
   endfunction

endpackage

// File: rtl/vrased_rst_log.sv
// Sticky cause register and saturating episode counter for attestation reporting.
// Instantiated by vrased_rst_ctrl only under VRASED_RST_LOG_EN.
module vrased_rst_log
   import vrased_rst_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic [NCAUSE-1:0] set,
   input  logic              inc,
   output logic [NCAUSE-1:0] cause,
   output logic [CNT_W-1:0]  viol_cnt
);

   // A clear that coincides with an event restarts the log from that event.
   always_ff @(posedge clk) begin
      if (reset) begin
         cause    <= '0;
         viol_cnt <= '0;
      end else if (clr) begin
         cause    <= set;
         viol_cnt <= inc ? CNT_W'(1) : '0;
      end else begin
         cause <= cause | set;
         if (inc && (viol_cnt != {CNT_W{1'b1}}))
            viol_cnt <= viol_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/vrased_rst_ctrl.sv
// Reset sequencer: combinational reset on any VRASED violation, minimum-width hold,
// then waits for a reset-handler fetch. Cause log present when VRASED_RST_LOG_EN is defined.
module vrased_rst_ctrl
   import vrased_rst_pkg::*;
#(
   parameter int          RST_CYCLES    = 16,
   parameter logic [15:0] RESET_HANDLER = 16'h0000,
   parameter int          ACK_TIMEOUT   = 64,
   parameter int          CNT_W         = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NVIOL-1:0]  viol,
   input  logic [15:0]       pc,
   input  logic              clear_log,
   output logic              sys_rst,
   output logic              rst_done,
   output logic              busy,
   output logic [NCAUSE-1:0] cause,
   output logic [CNT_W-1:0]  viol_cnt
);

   localparam int HW = cnt_width(RST_CYCLES);
   localparam int WW = cnt_width(ACK_TIMEOUT);

   state_e          state, next;
   logic [HW-1:0]   hold_cnt;
   logic [WW-1:0]   wait_cnt;
   logic            rst_done_q;
   logic            any_viol, hold_done, wait_to, fetch, timeout;

   assign any_viol  = |viol;
   assign hold_done = (hold_cnt == '0);
   assign wait_to   = (wait_cnt == WW'(ACK_TIMEOUT - 1));
   assign fetch     = (pc == RESET_HANDLER);
   assign timeout   = (state == ST_WAIT_FETCH) && !any_viol && !fetch && wait_to;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_HOLD;
         rst_done_q <= 1'b0;
      end else begin
         state      <= next;
         rst_done_q <= (state == ST_WAIT_FETCH) && (next == ST_IDLE);
      end
   end

   always_comb begin
      next = state;
      case (state)
         ST_IDLE:       if (any_viol) next = ST_HOLD;
         ST_HOLD:       if (!any_viol && hold_done) next = ST_WAIT_FETCH;
         ST_WAIT_FETCH: begin
            if (any_viol)     next = ST_HOLD;
            else if (fetch)   next = ST_IDLE;
            else if (wait_to) next = ST_HOLD;
         end
         default:       next = ST_HOLD;
      endcase
   end

   always_comb begin
      sys_rst  = reset | any_viol | (state == ST_HOLD);
      busy     = (state != ST_IDLE);
      rst_done = rst_done_q;
   end

   // Both counters sit at their entry value outside their own state, so every entry starts fresh.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt <= HW'(RST_CYCLES - 1);
         wait_cnt <= '0;
      end else begin
         if (state != ST_HOLD || any_viol) hold_cnt <= HW'(RST_CYCLES - 1);
         else if (!hold_done)              hold_cnt <= hold_cnt - HW'(1);
         if (state != ST_WAIT_FETCH)       wait_cnt <= '0;
         else if (!wait_to)                wait_cnt <= wait_cnt + WW'(1);
      end
   end

`ifdef VRASED_RST_LOG_EN
   logic [NCAUSE-1:0] log_set;
   logic              log_inc, log_clr;

   assign log_set = {timeout, viol};
   assign log_inc = any_viol && (state == ST_IDLE || state == ST_WAIT_FETCH);
   assign log_clr = (state == ST_IDLE) && clear_log;

   vrased_rst_log #(.CNT_W(CNT_W)) u_log (
      .clk      (clk),
      .reset    (reset),
      .clr      (log_clr),
      .set      (log_set),
      .inc      (log_inc),
      .cause    (cause),
      .viol_cnt (viol_cnt)
   );
`else
   logic unused_log;
   assign unused_log = clear_log ^ timeout;
   assign cause      = '0;
   assign viol_cnt   = '0;
`endif

endmodule

// File: tb/tb_vrased_rst_ctrl.sv
// Randomized scoreboard bench for vrased_rst_ctrl against a phase-level reference model.
// Expected log values follow VRASED_RST_LOG_EN the same way the design build does.
module tb_vrased_rst_ctrl;

   localparam int          RST    = 16;
   localparam logic [15:0] HANDLER = 16'h0000;
   localparam int          ACK    = 64;
   localparam int          CW     = 8;
   localparam int          CMAX   = (1 << CW) - 1;
`ifdef VRASED_RST_LOG_EN
   localparam bit LOG = 1'b1;
`else
   localparam bit LOG = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [5:0]    viol = '0;
   logic [15:0]   pc = 16'h1234;
   logic          clear_log = 1'b0;
   logic          sys_rst, rst_done, busy;
   logic [6:0]    cause;
   logic [CW-1:0] viol_cnt;

   vrased_rst_ctrl #(.RST_CYCLES(RST), .RESET_HANDLER(HANDLER), .ACK_TIMEOUT(ACK), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .viol(viol), .pc(pc), .clear_log(clear_log),
      .sys_rst(sys_rst), .rst_done(rst_done), .busy(busy), .cause(cause), .viol_cnt(viol_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       sys_rst;
      bit       busy;
      bit       rst_done;
      bit [6:0] cause;
      int       cnt;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0, n_pass = 0;

   // Reference model: phase 0=idle, 1=holding, 2=waiting for fetch.
   int       ph = 1, hold_left = RST, waited = 0, m_cnt = 0;
   bit [6:0] m_cause = '0;
   bit       m_done = 0;

   task automatic model_update(input bit r, input bit [5:0] v, input bit [15:0] p, input bit c);
      if (r) begin
         ph = 1; hold_left = RST; waited = 0; m_cause = '0; m_cnt = 0; m_done = 0;
         return;
      end
      m_done = 0;
      case (ph)
         0: begin
            if (c) begin m_cause = '0; m_cnt = 0; end
            if (v != 0) begin
               ph = 1; hold_left = RST; m_cause |= {1'b0, v};
               m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end
         end
         1: begin
            if (v != 0) begin m_cause |= {1'b0, v}; hold_left = RST; end
            else if (hold_left == 1) begin ph = 2; waited = 0; end
            else hold_left--;
         end
         default: begin
            if (v != 0) begin
               ph = 1; hold_left = RST; m_cause |= {1'b0, v};
               m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end else if (p == HANDLER) begin
               ph = 0; m_done = 1;
            end else if (waited + 1 == ACK) begin
               ph = 1; hold_left = RST; m_cause[6] = 1'b1;
            end else waited++;
         end
      endcase
   endtask

   // Drive one cycle of inputs, queue what the outputs must be during that cycle, advance the model.
   task automatic step(input bit r, input bit [5:0] v, input bit [15:0] p, input bit c);
      exp_t e;
      reset = r; viol = v; pc = p; clear_log = c;
      e.sys_rst  = r || (v != 0) || (ph == 1);
      e.busy     = (ph != 0);
      e.rst_done = m_done;
      e.cause    = LOG ? m_cause : 7'h0;
      e.cnt      = LOG ? m_cnt : 0;
      q.push_back(e);
      @(posedge clk);
      model_update(r, v, p, c);
      #1;
   endtask

   task automatic run(input int n, input int pv_idle, input int pv_hold, input int pv_wait,
                      input int ppc, input int pclr, input int prst);
      bit [5:0]  v;
      bit [15:0] p;
      int        pv;
      for (int i = 0; i < n; i++) begin
         pv = (ph == 0) ? pv_idle : (ph == 1) ? pv_hold : pv_wait;
         v  = ($urandom_range(0, 999) < pv) ?
              (($urandom_range(0, 1) == 0) ? 6'(1 << $urandom_range(0, 5)) : 6'($urandom_range(1, 63))) : 6'h0;
         p  = ($urandom_range(0, 999) < ppc) ? HANDLER : (HANDLER ^ 16'($urandom_range(1, 65535)));
         step($urandom_range(0, 999) < prst, v, p, $urandom_range(0, 999) < pclr);
      end
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_chk++;
      if (act == req) n_pass++;
      else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("sys_rst",  int'(sys_rst),  int'(e.sys_rst));
         chk("busy",     int'(busy),     int'(e.busy));
         chk("rst_done", int'(rst_done), int'(e.rst_done));
         chk("cause",    int'(cause),    int'(e.cause));
         chk("viol_cnt", int'(viol_cnt), e.cnt);
      end
   end

   initial begin
      // The first reset edge establishes a known state before anything is queued.
      @(posedge clk);
      model_update(1'b1, '0, 16'h1234, 1'b0);
      #1;
      step(1'b1, '0, 16'h1234, 1'b0);
      step(1'b1, '0, 16'h1234, 1'b0);
      run(40, 0, 0, 0, 1000, 0, 0);          // power-on recovery
      run(300, 50, 0, 0, 1000, 0, 0);        // isolated IDLE violations
      run(400, 30, 60, 0, 1000, 0, 0);       // violations extending HOLD
      step(1'b0, 6'b000010, 16'h1234, 1'b0);
      run(300, 0, 0, 0, 0, 0, 0);            // no fetch: repeated ack timeouts
      run(6000, 1000, 0, 0, 1000, 0, 0);     // back-to-back episodes past saturation
      run(60, 0, 0, 0, 1000, 0, 0);
      step(1'b0, 6'b000001, 16'h1234, 1'b1); // clear and violation together in IDLE
      run(40, 0, 0, 0, 1000, 0, 0);
      run(500, 100, 0, 20, 300, 300, 0);
      run(3000, 50, 30, 30, 100, 100, 5);
      @(negedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
